// File: rtl/icdf_rr_scheduler_if.sv
// icdf_rr_scheduler_if: requester, pipeline and response handshakes of the
// shared inverse-CDF scheduler.
interface icdf_rr_scheduler_if #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*WIDTH-1:0] req_data, rsp_data;
   logic                  pipe_valid, pipe_ready, res_valid, res_ready;
   logic [WIDTH-1:0]      pipe_data, res_data;
   modport master (
      input  req_valid, req_data, pipe_ready, res_valid, res_data, rsp_ready,
      output req_ready, pipe_valid, pipe_data, res_ready, rsp_valid, rsp_data
   );
   modport slave (
      output req_valid, req_data, pipe_ready, res_valid, res_data, rsp_ready,
      input  req_ready, pipe_valid, pipe_data, res_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/icdf_rr_scheduler.sv
// icdf_rr_scheduler: round-robin share of one in-order inverse-CDF pipeline
// among NREQ sample streams; a tag FIFO routes each result back to its issuer.
module icdf_rr_scheduler #(
   parameter int  WIDTH = 32,
   parameter int  NREQ  = 4,
   parameter int  DEPTH = 8,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   icdf_rr_scheduler_if.master bus,
   output logic [CW-1:0]       inflight_o,
   output logic                err_orphan_o
);
   logic             issue_valid_q, issue_valid_d;
   logic [WIDTH-1:0] issue_data_q, issue_data_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   tag_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_q;
   logic [IDW-1:0]   win, head;
   logic             found, load_ok, space, grant, empty, pop;

   assign empty   = cnt_q == '0;
   assign head    = tag_q[rd_q];
   assign pop     = !empty && bus.res_valid && bus.rsp_ready[head];
   assign load_ok = !issue_valid_q || bus.pipe_ready;
   // A same-cycle pop frees the slot a full FIFO needs for the push.
   assign space   = cnt_q < CW'(DEPTH) || pop;
   assign grant   = rst_n && found && load_ok && space;

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && bus.req_valid[(int'(ptr_q) + i) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   assign bus.req_ready  = grant ? NREQ'(1) << win : '0;
   assign bus.pipe_valid = issue_valid_q;
   assign bus.pipe_data  = issue_data_q;
   assign bus.rsp_valid  = (empty || !bus.res_valid) ? '0 : NREQ'(1) << head;
   assign bus.rsp_data   = {NREQ{bus.res_data}};
   // An empty FIFO still accepts results so orphans are drained and flagged.
   assign bus.res_ready  = empty || bus.rsp_ready[head];
   assign inflight_o     = cnt_q;
   assign err_orphan_o   = err_q;

   always_comb begin
      issue_valid_d = grant ? 1'b1 : (bus.pipe_ready ? 1'b0 : issue_valid_q);
      issue_data_d  = grant ? bus.req_data[int'(win)*WIDTH +: WIDTH] : issue_data_q;
      ptr_d         = grant ? win : ptr_q;
      cnt_d         = cnt_q + CW'(grant) - CW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid_q <= 1'b0;
         issue_data_q  <= '0;
         ptr_q         <= IDW'(NREQ - 1);
         wr_q          <= '0;
         rd_q          <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_data_q  <= issue_data_d;
         ptr_q         <= ptr_d;
         cnt_q         <= cnt_d;
         if (grant) begin
            tag_q[wr_q] <= win;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         if (empty && bus.res_valid) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_icdf_rr_scheduler.sv
// tb_icdf_rr_scheduler: directed vector table for arbitration, backpressure and
// saturation, plus hand sequences for routing, head-of-line stall and orphans.
module tb_icdf_rr_scheduler;
   localparam int W = 32, N = 4, D = 8;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [3:0] inflight;
   logic       err_orphan;
   int         checks = 0, errors = 0;

   icdf_rr_scheduler_if #(.WIDTH(W), .NREQ(N)) bus ();

   icdf_rr_scheduler #(.WIDTH(W), .NREQ(N), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.master),
      .inflight_o(inflight), .err_orphan_o(err_orphan)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic        pr;
      logic        resv;
      logic [3:0]  rr;
      logic [3:0]  e_rr;
      logic        e_pv;
      logic [31:0] e_pd;
      logic [3:0]  e_inf;
      logic        e_resr;
      logic [3:0]  e_rspv;
   } vec_t;

   vec_t tv [19];

   function automatic vec_t mk(logic [3:0] rv, logic pr, logic resv, logic [3:0] rr,
                               logic [3:0] e_rr, logic e_pv, logic [31:0] e_pd,
                               logic [3:0] e_inf, logic e_resr, logic [3:0] e_rspv);
      vec_t v;
      v.rv = rv; v.pr = pr; v.resv = resv; v.rr = rr; v.e_rr = e_rr; v.e_pv = e_pv;
      v.e_pd = e_pd; v.e_inf = e_inf; v.e_resr = e_resr; v.e_rspv = e_rspv;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Requests 0..3 always offer 0x4000+i.
      for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'h0000_4000 + i;
      bus.req_valid = '0; bus.pipe_ready = 1'b1; bus.res_valid = 1'b0;
      bus.res_data = '0; bus.rsp_ready = '1;
      // rv pr resv rr | req_ready pipe_valid pipe_data inflight res_ready rsp_valid
      tv[0]  = mk(4'hF, 1, 0, 4'hF, 4'h1, 0, 32'h0,    0, 1, 4'h0);
      tv[1]  = mk(4'hF, 1, 0, 4'hF, 4'h2, 1, 32'h4000, 1, 1, 4'h0);
      tv[2]  = mk(4'hF, 1, 0, 4'hF, 4'h4, 1, 32'h4001, 2, 1, 4'h0);
      tv[3]  = mk(4'hF, 1, 0, 4'hF, 4'h8, 1, 32'h4002, 3, 1, 4'h0);
      tv[4]  = mk(4'hF, 1, 0, 4'hF, 4'h1, 1, 32'h4003, 4, 1, 4'h0);
      tv[5]  = mk(4'hA, 1, 1, 4'hF, 4'h2, 1, 32'h4000, 5, 1, 4'h1);
      tv[6]  = mk(4'hA, 1, 1, 4'hF, 4'h8, 1, 32'h4001, 5, 1, 4'h2);
      tv[7]  = mk(4'hA, 1, 1, 4'hF, 4'h2, 1, 32'h4003, 5, 1, 4'h4);
      tv[8]  = mk(4'hA, 1, 1, 4'hF, 4'h8, 1, 32'h4001, 5, 1, 4'h8);
      tv[9]  = mk(4'hF, 0, 0, 4'hF, 4'h0, 1, 32'h4003, 5, 1, 4'h0);
      tv[10] = mk(4'hF, 0, 0, 4'hF, 4'h0, 1, 32'h4003, 5, 1, 4'h0);
      tv[11] = mk(4'hF, 0, 0, 4'hF, 4'h0, 1, 32'h4003, 5, 1, 4'h0);
      tv[12] = mk(4'hF, 1, 0, 4'hF, 4'h1, 1, 32'h4003, 5, 1, 4'h0);
      tv[13] = mk(4'hF, 1, 0, 4'hF, 4'h2, 1, 32'h4000, 6, 1, 4'h0);
      tv[14] = mk(4'hF, 1, 0, 4'hF, 4'h4, 1, 32'h4001, 7, 1, 4'h0);
      tv[15] = mk(4'hF, 1, 0, 4'hF, 4'h0, 1, 32'h4002, 8, 1, 4'h0);
      tv[16] = mk(4'hF, 1, 0, 4'hF, 4'h0, 0, 32'h4002, 8, 1, 4'h0);
      tv[17] = mk(4'hF, 1, 1, 4'hF, 4'h8, 0, 32'h4002, 8, 1, 4'h1);
      tv[18] = mk(4'hF, 1, 0, 4'hF, 4'h0, 1, 32'h4003, 8, 1, 4'h0);

      #2;
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_err", 32'(err_orphan), 0);
      chk("rst_pipe_valid", 32'(bus.pipe_valid), 0);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         bus.req_valid = tv[i].rv; bus.pipe_ready = tv[i].pr;
         bus.res_valid = tv[i].resv; bus.rsp_ready = tv[i].rr;
         bus.res_data  = 32'h0000_1000 + i;
         #1;
         chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(tv[i].e_rr));
         chk($sformatf("v%0d_pipe_valid", i), 32'(bus.pipe_valid), 32'(tv[i].e_pv));
         chk($sformatf("v%0d_pipe_data", i), bus.pipe_data, tv[i].e_pd);
         chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(tv[i].e_inf));
         chk($sformatf("v%0d_res_ready", i), 32'(bus.res_ready), 32'(tv[i].e_resr));
         chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tv[i].e_rspv));
         tick();
      end

      // Asynchronous reset with traffic still asserted.
      bus.req_valid = 4'hF; bus.pipe_ready = 1'b1; bus.res_valid = 1'b0; bus.rsp_ready = 4'hF;
      rst_n = 1'b0;
      #1;
      chk("ar_pipe_valid", 32'(bus.pipe_valid), 0);
      chk("ar_pipe_data", bus.pipe_data, 0);
      chk("ar_inflight", 32'(inflight), 0);
      chk("ar_req_ready", 32'(bus.req_ready), 0);
      chk("ar_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("ar_res_ready", 32'(bus.res_ready), 1);
      tick();
      rst_n = 1'b1;

      // Issue tags 2, 0, 3 one at a time.
      bus.req_valid = 4'h4; #1; chk("t_grant2", 32'(bus.req_ready), 32'h4); tick();
      bus.req_valid = 4'h1; #1; chk("t_grant0", 32'(bus.req_ready), 32'h1); tick();
      bus.req_valid = 4'h8; #1; chk("t_grant3", 32'(bus.req_ready), 32'h8); tick();
      bus.req_valid = 4'h0; #1; chk("t_inflight3", 32'(inflight), 3);

      bus.res_valid = 1'b1; bus.res_data = 32'hFFFF_8000;
      #1;
      chk("r1_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("r1_data2", bus.rsp_data[2*W +: W], 32'hFFFF_8000);
      chk("r1_data0", bus.rsp_data[0 +: W], 32'hFFFF_8000);
      chk("r1_res_ready", 32'(bus.res_ready), 1);
      tick();

      bus.res_data = 32'h0001_2000; bus.rsp_ready = 4'hE;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("hol%0d_rsp_valid", c), 32'(bus.rsp_valid), 32'h1);
         chk($sformatf("hol%0d_res_ready", c), 32'(bus.res_ready), 0);
         chk($sformatf("hol%0d_inflight", c), 32'(inflight), 2);
         tick();
      end
      bus.rsp_ready = 4'hF;
      #1;
      chk("r2_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("r2_res_ready", 32'(bus.res_ready), 1);
      chk("r2_data0", bus.rsp_data[0 +: W], 32'h0001_2000);
      tick();

      bus.res_data = 32'h0000_0123;
      #1;
      chk("r3_rsp_valid", 32'(bus.rsp_valid), 32'h8);
      chk("r3_data3", bus.rsp_data[3*W +: W], 32'h0000_0123);
      tick();

      // Orphan result with an empty FIFO.
      #1;
      chk("o_inflight0", 32'(inflight), 0);
      chk("o_res_ready", 32'(bus.res_ready), 1);
      chk("o_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("o_err_before", 32'(err_orphan), 0);
      tick();
      bus.res_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("o_err_sticky%0d", c), 32'(err_orphan), 1);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("o_err_cleared", 32'(err_orphan), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
